// File: rtl/serial_pkg.sv
// Shared status encoding between the shift datapath and its controller.
package serial_pkg;
  localparam int STAT_SHIFT = 0;
  localparam int STAT_WAIT  = 1;

  typedef logic [1:0] status_t;

  localparam status_t ST_WAIT  = 2'b10;
  localparam status_t ST_SHIFT = 2'b01;
  localparam status_t ST_DONE  = 2'b00;
endpackage

// File: rtl/bit_down_counter.sv
// Loadable down counter with a zero flag; clear beats decrement beats load.
module bit_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (clr)
      r_count <= '0;
    else if (dec)
      r_count <= r_count - 1'b1;
    else if (load)
      r_count <= load_val;
  end

  assign count = r_count;
  assign zero  = (r_count == '0);
endmodule

// File: rtl/serial_shift_datapath.sv
// Parallel-in, serial-out datapath with running parity and controller status.
// Define SERIAL_MSB_FIRST_EN to shift MSB first (default is LSB first).
module serial_shift_datapath
  import serial_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output status_t          status,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             parity,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] r_sreg;
  logic             r_loaded;
  logic             r_parity;
  logic             r_serial_out;
  logic             r_serial_valid;

  logic             w_zero;
  logic             w_shift_en;
  logic             w_load_en;
  logic             w_out_bit;
  logic [WIDTH-1:0] w_sreg_shifted;

  assign w_shift_en = shift && r_loaded && !w_zero;
  // Load is refused once loaded so a strobe held through shifting never re-captures.
  assign w_load_en  = load && !shift && !r_loaded && in_valid;

`ifdef SERIAL_MSB_FIRST_EN
  assign w_out_bit      = r_sreg[WIDTH-1];
  assign w_sreg_shifted = {r_sreg[WIDTH-2:0], 1'b0};
`else
  assign w_out_bit      = r_sreg[0];
  assign w_sreg_shifted = {1'b0, r_sreg[WIDTH-1:1]};
`endif

  bit_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .clr      (clear),
    .load     (w_load_en),
    .load_val (CNT_W'(WIDTH)),
    .dec      (w_shift_en),
    .count    (count),
    .zero     (w_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sreg         <= '0;
      r_loaded       <= 1'b0;
      r_parity       <= 1'b0;
      r_serial_out   <= 1'b0;
      r_serial_valid <= 1'b0;
    end else if (clear) begin
      r_sreg         <= '0;
      r_loaded       <= 1'b0;
      r_parity       <= 1'b0;
      r_serial_valid <= 1'b0;
    end else begin
      r_serial_valid <= w_shift_en;
      if (w_shift_en) begin
        r_serial_out <= w_out_bit;
        r_sreg       <= w_sreg_shifted;
        r_parity     <= r_parity ^ w_out_bit;
      end else if (w_load_en) begin
        r_sreg   <= data_in;
        r_loaded <= 1'b1;
      end
    end
  end

  assign status[STAT_SHIFT] = r_loaded && !w_zero;
  assign status[STAT_WAIT]  = !r_loaded;
  assign serial_out         = r_serial_out;
  assign serial_valid       = r_serial_valid;
  assign parity             = r_parity;

  a_no_status_11 : assert property (@(posedge clock) disable iff (reset) status != 2'b11);
endmodule
